// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// One byte is accepted per grant, loaded with a single-cycle strobe, and further
// grants are held off until the frame completes (or times out) plus a gap.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_parity_sel,
  input  logic [NUM_REQ-1:0]           req_stop_sel,
  input  logic [15:0]                  gap_cycles,
  input  logic                         tx_done,
  output logic                         tx_valid_in,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         tx_parity_sel,
  output logic                         tx_stop_sel,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned IDX_W = ID_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = 16;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] NUM_IDX   = IDX_W'(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_par_q, tx_par_d;
  logic                tx_stop_q, tx_stop_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic                timeout_q, timeout_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [IDX_W-1:0]    arb_idx;
  logic                grant_en;

  // Rotating-priority search starting at rr_ptr, wrapping back to rr_ptr-1
  always_comb begin : p_arb
    win_found = 1'b0;
    win_id    = '0;
    arb_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (arb_idx >= NUM_IDX) begin
        arb_idx = arb_idx - NUM_IDX;
      end
      if (!win_found && req_valid[arb_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = arb_idx[ID_W-1:0];
      end
    end
  end

  // Ready is combinational and suppressed while reset is held so no requester
  // believes a byte was taken by flops that are being cleared
  assign grant_en  = (state_q == S_IDLE) && reset_n && win_found;
  assign req_ready = grant_en ? (NUM_REQ'(1) << win_id) : '0;

  // Next-state and registered-output logic
  always_comb begin : p_next
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          tx_data_d  = req_data[win_id*DATA_W +: DATA_W];
          tx_par_d   = req_parity_sel[win_id];
          tx_stop_d  = req_stop_sel[win_id];
          grant_d    = win_id;
          rr_ptr_d   = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
          tx_valid_d = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Completion takes precedence over a coincident timeout
        if (tx_done) begin
          wait_cnt_d = '0;
          gap_cnt_d  = gap_cycles;
          state_d    = S_GAP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          gap_cnt_d  = gap_cycles;
          timeout_d  = 1'b1;
          state_d    = S_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin : p_regs
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_valid_in   = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign tx_parity_sel = tx_par_q;
  assign tx_stop_sel   = tx_stop_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected loads are queued at grant time
// and compared when the load strobe appears; a second instance covers timeout.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       p;
    logic       s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_ready, req_par, req_stop;
  logic [NR*DW-1:0]  req_data;
  logic [15:0]       gap_cycles;
  logic              tx_done, tx_valid_in, tx_parity_sel, tx_stop_sel, busy, timeout_err;
  logic [DW-1:0]     tx_data;
  logic [1:0]        grant_id;

  // short-timeout instance
  logic              t_rst_n;
  logic [NR-1:0]     t_req_valid, t_req_ready, t_req_par, t_req_stop;
  logic [NR*DW-1:0]  t_req_data;
  logic [15:0]       t_gap;
  logic              t_tx_done, t_tx_valid_in, t_tx_par, t_tx_stop, t_busy, t_timeout_err;
  logic [DW-1:0]     t_tx_data;
  logic [1:0]        t_grant_id;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_parity_sel(req_par), .req_stop_sel(req_stop), .gap_cycles(gap_cycles),
    .tx_done(tx_done), .tx_valid_in(tx_valid_in), .tx_data(tx_data),
    .tx_parity_sel(tx_parity_sel), .tx_stop_sel(tx_stop_sel), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .reset_n(t_rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_data(t_req_data),
    .req_parity_sel(t_req_par), .req_stop_sel(t_req_stop), .gap_cycles(t_gap),
    .tx_done(t_tx_done), .tx_valid_in(t_tx_valid_in), .tx_data(t_tx_data),
    .tx_parity_sel(t_tx_par), .tx_stop_sel(t_tx_stop), .busy(t_busy),
    .grant_id(t_grant_id), .timeout_err(t_timeout_err)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rr_m    = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_winner(input logic [NR-1:0] v, input int rr);
    for (int k = 0; k < int'(NR); k++) begin
      int i;
      i = (rr + k) % int'(NR);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int w);
    return (w < 0) ? 32'd0 : (32'd1 << w);
  endfunction

  // Pop the scoreboard on every load strobe from the main instance
  always @(negedge clk) begin
    if (tx_valid_in === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_load", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_data",   32'(tx_data),       32'(mon_e.d));
        chk("sb_parity", 32'(tx_parity_sel), 32'(mon_e.p));
        chk("sb_stop",   32'(tx_stop_sel),   32'(mon_e.s));
        chk("sb_grant",  32'(grant_id),      32'(mon_e.id));
      end
    end
  end

  // Entered and left at a negedge with the main DUT in IDLE
  task automatic run_frame(input logic [NR-1:0] vld, input int done_dly, input int gap, input bit keep);
    int   w;
    int   wn;
    exp_t e;
    req_valid  = vld;
    gap_cycles = 16'(gap);
    #1;
    w = exp_winner(vld, rr_m);
    chk("ready_grant", 32'(req_ready), onehot(w));
    e.id = w;
    e.d  = req_data[w*8 +: 8];
    e.p  = req_par[w];
    e.s  = req_stop[w];
    sb.push_back(e);
    rr_m = (w + 1) % int'(NR);
    @(negedge clk);
    if (!keep) req_valid = '0;
    #1;
    chk("load_strobe", 32'(tx_valid_in), 32'd1);
    chk("ready_load",  32'(req_ready),   32'd0);
    chk("busy_load",   32'(busy),        32'd1);
    repeat (done_dly) begin
      @(negedge clk);
      #1;
      chk("strobe_1cyc", 32'(tx_valid_in),   32'd0);
      chk("ready_wait",  32'(req_ready),     32'd0);
      chk("busy_wait",   32'(busy),          32'd1);
      chk("data_hold",   32'(tx_data),       32'(e.d));
      chk("par_hold",    32'(tx_parity_sel), 32'(e.p));
      chk("stop_hold",   32'(tx_stop_sel),   32'(e.s));
    end
    tx_done = 1'b1;
    for (int k = 1; k <= gap + 2; k++) begin
      @(negedge clk);
      tx_done = 1'b0;
      #1;
      if (k < gap + 2) begin
        chk("ready_gap", 32'(req_ready), 32'd0);
        chk("busy_gap",  32'(busy),      32'd1);
      end else begin
        wn = exp_winner(req_valid, rr_m);
        chk("busy_idle",  32'(busy),      32'd0);
        chk("ready_idle", 32'(req_ready), onehot(wn));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},  32'(req_ready),     32'd0);
    chk({tag, "_valid"},  32'(tx_valid_in),   32'd0);
    chk({tag, "_data"},   32'(tx_data),       32'd0);
    chk({tag, "_par"},    32'(tx_parity_sel), 32'd0);
    chk({tag, "_stop"},   32'(tx_stop_sel),   32'd0);
    chk({tag, "_busy"},   32'(busy),          32'd0);
    chk({tag, "_grant"},  32'(grant_id),      32'd0);
    chk({tag, "_tmo"},    32'(timeout_err),   32'd0);
  endtask

  task automatic reset_main();
    rst_n     = 1'b0;
    req_valid = '0;
    tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_m  = 0;
  endtask

  // Timeout instance: one frame, optionally with tx_done in the last WAIT cycle
  task automatic run_timeout(input bit with_done);
    t_req_valid = 4'b0001;
    #1;
    chk("to_ready", 32'(t_req_ready), 32'd1);
    @(negedge clk);
    t_req_valid = '0;
    #1;
    chk("to_load", 32'(t_tx_valid_in), 32'd1);
    chk("to_data", 32'(t_tx_data),     32'h3c);
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      t_tx_done = (with_done && j == 16);
      #1;
      chk(with_done ? "to_err_tie" : "to_err", 32'(t_timeout_err),
          32'((!with_done && j == 17) ? 1 : 0));
      chk("to_busy", 32'(t_busy), 32'((j <= 17) ? 1 : 0));
    end
    t_tx_done = 1'b0;
  endtask

  initial begin
    int w;
    exp_t e;
    rst_n = 1'b0; t_rst_n = 1'b0;
    req_valid = 4'b1111; req_par = 4'b1010; req_stop = 4'b1100;
    req_data = '0; gap_cycles = '0; tx_done = 1'b0;
    t_req_valid = '0; t_req_par = '0; t_req_stop = '0;
    t_req_data = 32'h0000_003c; t_gap = '0; t_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("rst");
    req_valid = '0;
    rst_n = 1'b1; t_rst_n = 1'b1;
    @(negedge clk);

    // single requester, late tx_done, no gap
    req_data[7:0] = 8'h55;
    run_frame(4'b0001, 20, 0, 1'b0);

    // fairness from a fresh pointer
    reset_main();
    req_data = 32'ha3a2_a1a0;
    for (int i = 0; i < 5; i++) run_frame(4'b1111, 3, 0, 1'b1);
    req_valid = '0;

    // one requester at a time, varied parity/stop
    run_frame(4'b0010, 6, 1, 1'b0);
    run_frame(4'b0100, 6, 1, 1'b0);
    run_frame(4'b1000, 6, 1, 1'b0);
    run_frame(4'b0001, 6, 1, 1'b0);

    // gap of 5 with another requester pending
    run_frame(4'b0011, 4, 5, 1'b1);
    run_frame(4'b0011, 2, 0, 1'b0);

    // timeout and tie with tx_done
    run_timeout(1'b0);
    run_timeout(1'b1);

    // reset during WAIT
    req_valid = 4'b0100; gap_cycles = '0;
    #1;
    w = exp_winner(req_valid, rr_m);
    chk("pre_rst_ready", 32'(req_ready), onehot(w));
    e.id = w; e.d = req_data[w*8 +: 8]; e.p = req_par[w]; e.s = req_stop[w];
    sb.push_back(e);
    rr_m = (w + 1) % int'(NR);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    rr_m = 0;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    chk("stale_busy",  32'(busy),        32'd0);
    chk("stale_valid", 32'(tx_valid_in), 32'd0);
    @(negedge clk);
    #1;
    chk("stale_busy2", 32'(busy), 32'd0);
    run_frame(4'b1111, 2, 0, 1'b0);

    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
